uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin scheduler sharing one UART transmitter among N_REQ byte sources.
//  Accepts one byte per grant over valid/ready, drives tx_data/tx_start to the transmitter,
//  then holds off the next grant until the frame completes (tx_empty high again).
//  Sits between on-chip byte producers (status, debug, command echo) and the UART TX path.
// PARAMETERS
//  N_REQ          4          number of requesters (2..16)
//  DATA_LEN       8          byte width; must match transmitter DATA_LEN
//  TIMEOUT_CYCLES 1_000_000  clk cycles allowed for tx_empty to fall after tx_start (timeout build only)
//  IDW (localparam) clog2(N_REQ), min 1
// PORTS
//  clk          in   1               system clock, all logic on posedge
//  rst          in   1               synchronous reset, active-low
//  req_valid    in   N_REQ           per-requester byte valid
//  req_data     in   N_REQ*DATA_LEN  packed bytes, requester i at [i*DATA_LEN +: DATA_LEN]
//  req_ready    out  N_REQ           one-hot accept strobe; transfer when valid&ready
//  tx_data      out  DATA_LEN        byte to transmitter, registered, stable START..DONE
//  tx_start     out  1               one-cycle pulse: tx_data is new, begin frame
//  tx_empty     in   1               transmitter idle (1) / frame in progress (0)
//  grant_id     out  IDW             index of requester owning current frame
//  busy         out  1               high in every state except IDLE
//  timeout_err  out  1               one-cycle pulse on transmitter no-response (timeout build only)
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=IDLE, rr pointer=N_REQ-1 (req 0 wins first), tx_data=0,
//   tx_start=0, grant_id=0, busy=0, timeout_err=0, req_ready=0. Reset mid-frame aborts
//   immediately; transmitter finishes on its own; IDLE gating on tx_empty prevents overlap.
//  FSM: IDLE -> START -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//  IDLE: if tx_empty=1 and |req_valid: winner = first valid index after pointer (wrapping
//   N_REQ-1 -> 0); req_ready[winner]=1 combinationally, all others 0. At that edge capture
//   req_data[winner] into tx_data, grant_id<=winner, pointer<=winner, go START.
//   If tx_empty=0 or no valid: req_ready=0, stay IDLE.
//  START: tx_start=1 for exactly this cycle -> WAIT_BUSY. Latency valid-seen -> tx_start = 1 clk.
//  WAIT_BUSY: wait tx_empty=0 -> WAIT_DONE. req_ready=0.
//  WAIT_DONE: wait tx_empty=1 -> IDLE. Next grant earliest the cycle after return to IDLE.
//  Requester rules: hold req_valid and req_data stable until accepted; deasserting valid before
//   accept is legal (arbitration re-evaluated every IDLE cycle, no grant reserved).
//  Single requester valid continuously: served every frame, pointer stays on it.
//  All N_REQ valid continuously: grant order 0,1,..,N_REQ-1,0,... (strict rotation).
//  Simultaneous accept and new valid on same requester: next byte competes next IDLE.
//  tx_data, grant_id hold last value while idle; busy is a decode of state.
// CONFIGURATION
//  Macro UART_ARB_TIMEOUT_EN.
//  Defined: cycle counter runs in WAIT_BUSY; reaching TIMEOUT_CYCLES-1 with tx_empty still 1
//   -> timeout_err pulse 1 cycle, state IDLE, byte dropped, pointer already advanced.
//  Undefined: no counter, WAIT_BUSY waits indefinitely, timeout_err tied 0, TIMEOUT_CYCLES unused.
// STRUCTURE
//  uart_pkg: FSM state encoding (ST_IDLE..ST_WAIT_DONE, 2-bit), clog2 function, shared with
//   uart_rx/uart_tx controllers.
//  Sub-module rr_arbiter (N_REQ): inputs req vector, pointer, enable; output one-hot grant and
//   binary index; purely combinational, pointer register stays in uart_tx_arbiter.
// TESTING
//  Bench models transmitter: tx_empty falls 2 clk after tx_start, rises 20 clk later.
//  1 Single: req_valid=4'b0010, data1=8'hA5 -> req_ready=4'b0010 one cycle, tx_start next clk,
//    tx_data=8'hA5, grant_id=1, busy high until tx_empty returns 1.
//  2 All valid, data i=8'h10+i, hold 8 frames -> tx_data sequence 10,11,12,13,10,11,12,13.
//  3 Backpressure: tx_empty forced 0 at reset release, req_valid=4'b0001 -> no req_ready until
//    tx_empty=1, then accept within 1 clk.
//  4 Reset mid-frame: rst=0 during WAIT_DONE -> next clk state IDLE, busy=0, tx_start=0,
//    pointer back to N_REQ-1; following request from req 3 and req 0 grants req 0 first.
//  5 Withdraw: req 2 valid 1 cycle while busy then drops -> never accepted, no tx_start.
//  6 (UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16) tx_empty stuck 1 after tx_start -> timeout_err
//    pulse 16 clk after entering WAIT_BUSY, state IDLE, next requester granted normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART controllers: frame-scheduler state encoding and
// a width helper that never returns less than one bit.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request strictly after the
// pointer position (wrapping), reported as a one-hot grant and a binary index.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   idx
);

    logic [IDW-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDW'((int'(ptr) + k) % N_REQ);
            if (en && req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte sources.
// Optional transmitter no-response timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  N_REQ          = 4,
    parameter int  DATA_LEN       = 8,
    parameter int  TIMEOUT_CYCLES = 1_000_000,
    localparam int IDW            = clog2_min1(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_LEN-1:0] req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [DATA_LEN-1:0]       tx_data,
    output logic                      tx_start,
    input  logic                      tx_empty,
    output logic [IDW-1:0]            grant_id,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int             CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDW-1:0] PTR_RST = IDW'(N_REQ - 1);

    state_e                state_q, state_d;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [DATA_LEN-1:0]   tx_data_q, tx_data_d;
    logic [IDW-1:0]        grant_id_q, grant_id_d;
    logic                  tx_start_q, tx_start_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  arb_en;
    logic [N_REQ-1:0]      win_onehot;
    logic [IDW-1:0]        win_idx;
    logic [DATA_LEN-1:0]   lane [N_REQ];

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic [CNT_W-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        assign lane[g] = req_data[g*DATA_LEN +: DATA_LEN];
    end

    // Arbitration is only live in IDLE with the transmitter free, and never in reset.
    assign arb_en = rst && (state_q == ST_IDLE) && tx_empty;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .en    (arb_en),
        .grant (win_onehot),
        .idx   (win_idx)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        tx_start_d    = 1'b0;
        timeout_err_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|win_onehot) begin
                    tx_data_d  = lane[win_idx];
                    grant_id_d = win_idx;
                    ptr_d      = win_idx;
                    tx_start_d = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT_BUSY: begin
                if (!tx_empty) begin
                    state_d = ST_WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    // Transmitter never picked the byte up: drop it and free the line.
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            ST_WAIT_DONE: begin
                if (tx_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= PTR_RST;
            tx_data_q     <= '0;
            grant_id_q    <= '0;
            tx_start_q    <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            tx_data_q     <= tx_data_d;
            grant_id_q    <= grant_id_d;
            tx_start_q    <= tx_start_d;
            timeout_err_q <= timeout_err_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign req_ready   = win_onehot;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign grant_id    = grant_id_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = timeout_err_q;

endmodule
